// File: rtl/buffer_writer_ctrl_if.sv
// Stream-in / buffer-write / reader-handshake bundle for buffer_writer_ctrl.
// master = upstream source and reader side, slave = the controller.
interface buffer_writer_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              data_done;
    logic              data_rdy;
    logic              frame_err;
    logic [7:0]        frame_cnt;

    modport master (
        output in_data, in_valid, in_last, data_rdy,
        input  in_ready, mem_we, mem_addr, mem_din, data_done, frame_err, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, in_last, data_rdy,
        output in_ready, mem_we, mem_addr, mem_din, data_done, frame_err, frame_cnt
    );
endinterface

// File: rtl/buffer_writer_ctrl.sv
// Writes one frame of stream words into a buffer, then hands ownership to the
// reader until it has finished consuming the frame.
module buffer_writer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int N_WORDS = 192
) (
    input  logic                 clk,
    input  logic                 reset,
    buffer_writer_ctrl_if.slave  bus
);
    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam logic [7:0] LAST_IDX = 8'(N_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              mem_we_q;
    logic [7:0]        mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              data_done_q;
    logic              frame_err_q;
    logic              accept;
    logic              at_last;

    assign accept  = bus.in_valid && (state_q == FILL);
    assign at_last = (wcnt_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (at_last) begin
                        state_d = FLUSH;
                        wcnt_d  = 8'd0;
                    end else if (bus.in_last) begin
                        // early last: frame is dropped, restart at word 0
                        wcnt_d  = 8'd0;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                    end
                end
            end
            FLUSH: begin
                state_d     = FULL;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            FULL:    if (bus.data_rdy)  state_d = DRAIN;
            DRAIN:   if (!bus.data_rdy) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            wcnt_q      <= 8'd0;
            frame_cnt_q <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_din_q   <= '0;
            data_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            frame_cnt_q <= frame_cnt_d;
            mem_we_q    <= accept;
            if (accept) begin
                mem_addr_q <= wcnt_q;
                mem_din_q  <= bus.in_data;
            end
            // in_last must coincide with the final word; either mismatch is an error
            frame_err_q <= accept && (bus.in_last != at_last);
            data_done_q <= (state_d == FULL);
        end
    end

    assign bus.in_ready  = (state_q == FILL);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.data_done = data_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_buffer_writer_ctrl.sv
// Randomized bench for buffer_writer_ctrl: a frame-level model predicts every
// buffer write, error pulse and frame count; handshake timing is checked inline.
module tb_buffer_writer_ctrl;
    localparam int DW = 8;
    localparam int NW = 192;

    typedef struct packed {
        logic [7:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    buffer_writer_ctrl_if #(.DATA_W(DW)) bus ();

    buffer_writer_ctrl #(.DATA_W(DW), .N_WORDS(NW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_chk   = 0;
    int  n_fail  = 0;
    int  idx     = 0;   // model: position of next word within the frame
    int  frames  = 0;
    int  err_exp = 0;
    int  err_seen = 0;
    int  we_cnt  = 0;
    wr_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // frame rules: words numbered 0..NW-1, last must land on NW-1
    function automatic void model_accept(input logic [DW-1:0] d, input bit last);
        exp_q.push_back('{addr: 8'(idx), data: d});
        if (idx == NW - 1) begin
            if (!last) err_exp++;
            idx = 0;
            frames++;
        end else if (last) begin
            err_exp++;
            idx = 0;
        end else begin
            idx++;
        end
    endfunction

    task automatic beat(input logic [DW-1:0] d, input bit last, input bit vld);
        bus.in_valid = vld;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        if (vld) chk("in_ready", bus.in_ready, 1);
        @(posedge clk);
        if (vld) model_accept(d, last);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_words(input int first, input bit with_last);
        for (int i = first; i < NW; i++)
            beat(DW'($urandom), with_last && (i == NW - 1), 1'b1);
    endtask

    task automatic release_frame(input int wait_cyc);
        int bad = 0;
        repeat (wait_cyc) begin
            if (bus.in_ready !== 1'b0 || bus.data_done !== 1'b1) bad++;
            tick();
        end
        chk("full_hold", bad, 0);
        bus.data_rdy = 1'b1;
        tick();
        chk("done_fall", bus.data_done, 0);
        chk("drain_ready", bus.in_ready, 0);
        tick();
        tick();
        bus.data_rdy = 1'b0;
        chk("drain_ready2", bus.in_ready, 0);
        tick();
        chk("ready_back", bus.in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            wr_t e;
            we_cnt++;
            chk("wr_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", bus.mem_din, e.data);
            end
        end
        if (rst_n && bus.frame_err) err_seen++;
    end

    initial begin
        int sent;
        int guard;
        int we0;
        bit v;

        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.data_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_din", bus.mem_din, 0);
        chk("rst_done", bus.data_done, 0);
        chk("rst_err", bus.frame_err, 0);
        chk("rst_cnt", bus.frame_cnt, 0);
        chk("rst_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // full frame, continuous valid
        send_words(0, 1'b1);
        chk("flush_ready", bus.in_ready, 0);
        chk("flush_we", bus.mem_we, 1);
        chk("flush_done", bus.data_done, 0);
        tick();
        chk("done_rise", bus.data_done, 1);
        chk("cnt_a", bus.frame_cnt, 8'(frames));
        chk("err_a", err_seen, err_exp);
        release_frame(300);

        // early last on word 50
        for (int i = 0; i <= 50; i++) beat(DW'($urandom), i == 50, 1'b1);
        chk("early_err", bus.frame_err, 1);
        chk("early_cnt", bus.frame_cnt, 8'(frames));
        beat(DW'($urandom), 1'b0, 1'b1);
        chk("early_addr0", bus.mem_addr, 0);
        send_words(1, 1'b1);
        bus.data_rdy = 1'b1;   // reader already waiting on entry to FULL
        tick();
        chk("pre_rdy_done", bus.data_done, 1);
        chk("cnt_b", bus.frame_cnt, 8'(frames));
        tick();
        chk("pre_rdy_fall", bus.data_done, 0);
        chk("pre_rdy_ready", bus.in_ready, 0);
        bus.data_rdy = 1'b0;
        tick();
        chk("pre_rdy_back", bus.in_ready, 1);

        // missing last
        send_words(0, 1'b0);
        chk("miss_err", bus.frame_err, 1);
        tick();
        chk("miss_done", bus.data_done, 1);
        chk("cnt_c", bus.frame_cnt, 8'(frames));
        release_frame(5);

        // gapped valid
        we0 = we_cnt;
        sent = 0;
        guard = 0;
        while (sent < NW && guard < 3000) begin
            v = 1'($urandom_range(0, 1));
            beat(DW'($urandom), v && (sent == NW - 1), v);
            if (v) sent++;
            guard++;
        end
        chk("gap_sent", sent, NW);
        tick();
        chk("gap_we", we_cnt - we0, NW);
        chk("gap_done", bus.data_done, 1);
        chk("cnt_d", bus.frame_cnt, 8'(frames));
        release_frame(3);

        // reset in the middle of a frame
        for (int i = 0; i < 100; i++) beat(DW'($urandom), 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'($urandom);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", bus.mem_we, 0);
        chk("arst_addr", bus.mem_addr, 0);
        chk("arst_din", bus.mem_din, 0);
        chk("arst_done", bus.data_done, 0);
        chk("arst_err", bus.frame_err, 0);
        chk("arst_cnt", bus.frame_cnt, 0);
        exp_q.delete();
        idx    = 0;
        frames = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("arst_hold_we", bus.mem_we, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        chk("arst_ready", bus.in_ready, 1);
        send_words(0, 1'b1);
        tick();
        chk("post_rst_done", bus.data_done, 1);
        chk("post_rst_cnt", bus.frame_cnt, 1);

        chk("err_total", err_seen, err_exp);
        chk("q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
